// File: rtl/sensor_disp_seq_if.sv
// Signal bundle between the sensor bring-up sequencer and its board-level driver.
// The master modport drives stimulus (button, calibration, samples); slave is the sequencer.
interface sensor_disp_seq_if #(
   parameter int NUM_CH = 3,
   parameter int DATA_W = 16,
   parameter int LED_W  = 8
) ();
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // vld has no ready: the sequencer never stalls, so every clk with vld=1
   // presents a complete sample set on ch_data that is taken on that edge in SHOW.
   logic                     next;
   logic                     cal_done;
   logic                     vld;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic                     strt_cal;
   logic                     cal_busy;
   logic [SEL_W-1:0]         ch_sel;
   logic [LED_W-1:0]         led;
   logic [1:0]               state_dbg;

   modport master (
      output next, cal_done, vld, ch_data,
      input  strt_cal, cal_busy, ch_sel, led, state_dbg
   );

   modport slave (
      input  next, cal_done, vld, ch_data,
      output strt_cal, cal_busy, ch_sel, led, state_dbg
   );
endinterface

// File: rtl/sensor_disp_seq.sv
// Calibration-then-channel-display sequencer driving an LED bank from a slice of a sensor word.
// Optional macro SEQ_AUTO_ADV_EN adds a periodic channel auto-advance in SHOW.
module sensor_disp_seq #(
   parameter int NUM_CH    = 3,
   parameter int DATA_W    = 16,
   parameter int LED_W     = 8,
   parameter int SLICE_LSB = 1,
   parameter int CAL_TO    = 1000000,
   parameter int AUTO_CYC  = 50000000
) (
   input logic                clk,
   input logic                rst_n,
   sensor_disp_seq_if.slave   bus
);
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TO_W   = $clog2(CAL_TO);
   localparam int N_SLOT = 1 << SEL_W;

   typedef enum logic [1:0] {IDLE = 2'd0, CAL = 2'd1, SHOW = 2'd2, ERR = 2'd3} state_t;

   state_t              state_q, state_d;
   logic                strt_q, strt_d;
   logic                busy_q, busy_d;
   logic [SEL_W-1:0]    sel_q, sel_d, sel_inc;
   logic [DATA_W-1:0]   hreg_q, hreg_d;
   logic [LED_W-1:0]    led_q, led_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic                adv;

   // Padded to a power of two so any ch_sel value indexes a defined word.
   logic [DATA_W-1:0]   words [N_SLOT];

   for (genvar k = 0; k < N_SLOT; k++) begin : g_words
      if (k < NUM_CH) begin : g_real
         assign words[k] = bus.ch_data[k*DATA_W +: DATA_W];
      end else begin : g_pad
         assign words[k] = '0;
      end
   end

   assign sel_inc = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;

`ifdef SEQ_AUTO_ADV_EN
   localparam int AW = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;
   logic [AW-1:0] auto_q, auto_d;

   always_comb begin
      auto_d = '0;
      adv    = 1'b0;
      if (state_q == SHOW) begin
         if (bus.next || auto_q == AW'(AUTO_CYC - 1)) begin
            adv = 1'b1;
         end else begin
            auto_d = auto_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) auto_q <= '0;
      else        auto_q <= auto_d;
   end
`else
   logic unused_auto;
   assign unused_auto = ^AUTO_CYC;
   assign adv = (state_q == SHOW) && bus.next;
`endif

   always_comb begin
      state_d = state_q;
      strt_d  = 1'b0;
      sel_d   = sel_q;
      hreg_d  = hreg_q;
      to_d    = to_q;
      case (state_q)
         IDLE, ERR: begin
            if (bus.next) begin
               state_d = CAL;
               strt_d  = 1'b1;
               to_d    = '0;
            end
         end
         CAL: begin
            // cal_done is tested first so it wins on the timeout cycle.
            if (bus.cal_done) begin
               state_d = SHOW;
               sel_d   = '0;
               hreg_d  = words[0];
            end else if (to_q == TO_W'(CAL_TO - 1)) begin
               state_d = ERR;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         SHOW: begin
            if (adv) begin
               sel_d  = sel_inc;
               hreg_d = words[sel_inc];
            end else if (bus.vld) begin
               hreg_d = words[sel_q];
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CAL);
      case (state_d)
         CAL:     led_d = LED_W'(1);
         ERR:     led_d = '1;
         SHOW:    led_d = hreg_d[SLICE_LSB +: LED_W];
         default: led_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         strt_q  <= 1'b0;
         busy_q  <= 1'b0;
         sel_q   <= '0;
         hreg_q  <= '0;
         led_q   <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         strt_q  <= strt_d;
         busy_q  <= busy_d;
         sel_q   <= sel_d;
         hreg_q  <= hreg_d;
         led_q   <= led_d;
         to_q    <= to_d;
      end
   end

   assign bus.strt_cal  = strt_q;
   assign bus.cal_busy  = busy_q;
   assign bus.ch_sel    = sel_q;
   assign bus.led       = led_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_sensor_disp_seq.sv
// Bench for sensor_disp_seq: directed scenarios plus a randomized SHOW run against a
// channel/held-word model; covers SEQ_AUTO_ADV_EN when the macro is defined.
module tb_sensor_disp_seq;
   localparam int N    = 3;
   localparam int DW   = 16;
   localparam int LW   = 8;
   localparam int SL   = 1;
   localparam int CTO  = 100;
   localparam int ACYC = 10;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   sensor_disp_seq_if #(.NUM_CH(N), .DATA_W(DW), .LED_W(LW)) bus ();

   sensor_disp_seq #(
      .NUM_CH(N), .DATA_W(DW), .LED_W(LW), .SLICE_LSB(SL), .CAL_TO(CTO), .AUTO_CYC(ACYC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [LW-1:0] slice_of(input logic [DW-1:0] w);
      return LW'(w >> SL);
   endfunction

   function automatic logic [DW-1:0] word_of(input logic [N*DW-1:0] d, input int k);
      return d[k*DW +: DW];
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic pulse_next();
      bus.next = 1'b1;
      cyc();
      bus.next = 1'b0;
   endtask

   task automatic do_reset();
      bus.next = 1'b0; bus.cal_done = 1'b0; bus.vld = 1'b0;
      rst_n = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic enter_show();
      pulse_next();
      cyc();
      bus.cal_done = 1'b1;
      cyc();
      bus.cal_done = 1'b0;
   endtask

   task automatic test_reset();
      cyc();
      n_tests++; if (bus.strt_cal !== 1'b0) begin n_fail++; $display("FAIL rst_strt got=%b exp=0", bus.strt_cal); end
      n_tests++; if (bus.cal_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.cal_busy); end
      n_tests++; if (bus.ch_sel !== '0) begin n_fail++; $display("FAIL rst_sel got=%0d exp=0", bus.ch_sel); end
      n_tests++; if (bus.led !== '0) begin n_fail++; $display("FAIL rst_led got=%h exp=00", bus.led); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_start_cal();
      int c;
      bus.ch_data = {16'h0300, 16'h0200, 16'h01FE};
      pulse_next(); c = 0;
      n_tests++; if (bus.strt_cal !== 1'b1) begin n_fail++; $display("FAIL strt_on got=%b exp=1", bus.strt_cal); end
      n_tests++; if (bus.cal_busy !== 1'b1) begin n_fail++; $display("FAIL cal_busy got=%b exp=1", bus.cal_busy); end
      n_tests++; if (bus.led !== 8'h01) begin n_fail++; $display("FAIL cal_led got=%h exp=01", bus.led); end
      cyc(); c++;
      n_tests++; if (bus.strt_cal !== 1'b0) begin n_fail++; $display("FAIL strt_one got=%b exp=0", bus.strt_cal); end
      pulse_next(); c++;
      n_tests++; if (bus.strt_cal !== 1'b0) begin n_fail++; $display("FAIL strt_again got=%b exp=0", bus.strt_cal); end
      n_tests++; if (bus.cal_busy !== 1'b1 || bus.led !== 8'h01) begin n_fail++; $display("FAIL cal_ignore_next got=%b/%h exp=1/01", bus.cal_busy, bus.led); end
      while (c < 19) begin cyc(); c++; end
      bus.cal_done = 1'b1;
      cyc();
      bus.cal_done = 1'b0;
      n_tests++; if (bus.ch_sel !== 2'd0) begin n_fail++; $display("FAIL show_sel got=%0d exp=0", bus.ch_sel); end
      n_tests++; if (bus.led !== 8'hFF) begin n_fail++; $display("FAIL show_led got=%h exp=ff", bus.led); end
      n_tests++; if (bus.cal_busy !== 1'b0) begin n_fail++; $display("FAIL show_busy got=%b exp=0", bus.cal_busy); end
   endtask

   task automatic test_show_next();
      logic [1:0] exp_sel [3];
      logic [7:0] exp_led [3];
      exp_sel = '{2'd1, 2'd2, 2'd0};
      exp_led = '{8'h00, 8'h80, 8'hFF};
      for (int i = 0; i < 3; i++) begin
         pulse_next();
         n_tests++; if (bus.ch_sel !== exp_sel[i]) begin n_fail++; $display("FAIL next_sel[%0d] got=%0d exp=%0d", i, bus.ch_sel, exp_sel[i]); end
         n_tests++; if (bus.led !== exp_led[i]) begin n_fail++; $display("FAIL next_led[%0d] got=%h exp=%h", i, bus.led, exp_led[i]); end
      end
      bus.ch_data[15:0] = 16'h0154;
      bus.vld = 1'b1;
      cyc();
      bus.vld = 1'b0;
      n_tests++; if (bus.led !== 8'hAA) begin n_fail++; $display("FAIL vld_load got=%h exp=aa", bus.led); end
      bus.next = 1'b1; bus.vld = 1'b1;
      cyc();
      bus.next = 1'b0; bus.vld = 1'b0;
      n_tests++; if (bus.ch_sel !== 2'd1 || bus.led !== 8'h00) begin n_fail++; $display("FAIL next_vld got=%0d/%h exp=1/00", bus.ch_sel, bus.led); end
   endtask

   task automatic test_timeout();
      int c;
      do_reset();
      bus.ch_data = {16'h1234, 16'h5678, 16'h0024};
      pulse_next();
      for (int i = 1; i < CTO; i++) cyc();
      n_tests++; if (bus.cal_busy !== 1'b1 || bus.led !== 8'h01) begin n_fail++; $display("FAIL to_early got=%b/%h exp=1/01", bus.cal_busy, bus.led); end
      cyc();
      n_tests++; if (bus.led !== 8'hFF || bus.cal_busy !== 1'b0) begin n_fail++; $display("FAIL to_err got=%h/%b exp=ff/0", bus.led, bus.cal_busy); end
      cyc();
      n_tests++; if (bus.led !== 8'hFF || bus.strt_cal !== 1'b0) begin n_fail++; $display("FAIL err_hold got=%h/%b exp=ff/0", bus.led, bus.strt_cal); end
      pulse_next(); c = 0;
      n_tests++; if (bus.strt_cal !== 1'b1 || bus.cal_busy !== 1'b1 || bus.led !== 8'h01) begin n_fail++; $display("FAIL retry got=%b/%b/%h exp=1/1/01", bus.strt_cal, bus.cal_busy, bus.led); end
      cyc(); c++;
      n_tests++; if (bus.strt_cal !== 1'b0) begin n_fail++; $display("FAIL retry_one got=%b exp=0", bus.strt_cal); end
      while (c < CTO - 1) begin cyc(); c++; end
      bus.cal_done = 1'b1;
      cyc();
      bus.cal_done = 1'b0;
      n_tests++; if (bus.led !== slice_of(16'h0024) || bus.cal_busy !== 1'b0 || bus.ch_sel !== 2'd0) begin n_fail++; $display("FAIL done_wins got=%h/%b/%0d exp=%h/0/0", bus.led, bus.cal_busy, bus.ch_sel, slice_of(16'h0024)); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_next();
      repeat (5) cyc();
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (bus.cal_busy !== 1'b0 || bus.led !== '0 || bus.strt_cal !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cal got=%b/%h/%b exp=0/00/0", bus.cal_busy, bus.led, bus.strt_cal); end
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_tests++; if (bus.strt_cal !== 1'b0 || bus.cal_busy !== 1'b0 || bus.led !== '0) begin n_fail++; $display("FAIL rst_idle[%0d] got=%b/%b/%h exp=0/0/00", i, bus.strt_cal, bus.cal_busy, bus.led); end
      end
      bus.ch_data = {16'h0000, 16'h00F0, 16'h0002};
      enter_show();
      pulse_next();
      n_tests++; if (bus.ch_sel !== 2'd1 || bus.led !== 8'h78) begin n_fail++; $display("FAIL pre_rst_show got=%0d/%h exp=1/78", bus.ch_sel, bus.led); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (bus.ch_sel !== '0 || bus.led !== '0) begin n_fail++; $display("FAIL rst_mid_show got=%0d/%h exp=0/00", bus.ch_sel, bus.led); end
      cyc();
      rst_n = 1'b1;
      cyc();
      n_tests++; if (bus.ch_sel !== '0 || bus.led !== '0 || bus.cal_busy !== 1'b0) begin n_fail++; $display("FAIL rst_show_idle got=%0d/%h/%b exp=0/00/0", bus.ch_sel, bus.led, bus.cal_busy); end
   endtask

   task automatic test_random();
      int m_sel;
      int acnt;
      logic [DW-1:0] m_held;
      logic do_adv;
      do_reset();
      for (int k = 0; k < N; k++) bus.ch_data[k*DW +: DW] = DW'($urandom);
      m_held = word_of(bus.ch_data, 0);
      enter_show();
      m_sel = 0; acnt = 0;
      n_tests++; if (bus.led !== slice_of(m_held)) begin n_fail++; $display("FAIL rnd_entry got=%h exp=%h", bus.led, slice_of(m_held)); end
      for (int t = 0; t < 300; t++) begin
         bus.next = ($urandom_range(0, 3) == 0);
         bus.vld  = ($urandom_range(0, 2) == 0);
         for (int k = 0; k < N; k++) bus.ch_data[k*DW +: DW] = DW'($urandom);
         do_adv = bus.next;
`ifdef SEQ_AUTO_ADV_EN
         if (!do_adv && acnt == ACYC - 1) do_adv = 1'b1;
         acnt = do_adv ? 0 : acnt + 1;
`endif
         if (do_adv) begin
            m_sel  = (m_sel + 1) % N;
            m_held = word_of(bus.ch_data, m_sel);
         end else if (bus.vld) begin
            m_held = word_of(bus.ch_data, m_sel);
         end
         cyc();
         n_tests++; if (bus.ch_sel !== 2'(m_sel) || bus.led !== slice_of(m_held)) begin n_fail++; $display("FAIL rnd[%0d] got=%0d/%h exp=%0d/%h", t, bus.ch_sel, bus.led, m_sel, slice_of(m_held)); end
      end
      bus.next = 1'b0; bus.vld = 1'b0;
   endtask

`ifdef SEQ_AUTO_ADV_EN
   task automatic test_auto_adv();
      int m_sel;
      logic step;
      do_reset();
      bus.ch_data = {16'h0300, 16'h0200, 16'h01FE};
      enter_show();
      m_sel = 0;
      for (int t = 1; t <= 30; t++) begin
         if (t == 5) bus.next = 1'b1;
         cyc();
         bus.next = 1'b0;
         step = (t == 5) || (t < 5 && t % ACYC == 0) || (t > 5 && (t - 5) % ACYC == 0);
         if (step) m_sel = (m_sel + 1) % N;
         n_tests++; if (bus.ch_sel !== 2'(m_sel)) begin n_fail++; $display("FAIL auto[%0d] got=%0d exp=%0d", t, bus.ch_sel, m_sel); end
      end
   endtask
`else
   task automatic test_no_auto();
      do_reset();
      bus.ch_data = {16'h0300, 16'h0200, 16'h01FE};
      enter_show();
      repeat (3 * ACYC) cyc();
      n_tests++; if (bus.ch_sel !== 2'd0 || bus.led !== 8'hFF) begin n_fail++; $display("FAIL no_auto got=%0d/%h exp=0/ff", bus.ch_sel, bus.led); end
   endtask
`endif

   initial begin
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0;
      bus.next = 1'b0; bus.cal_done = 1'b0; bus.vld = 1'b0; bus.ch_data = '0;
      test_reset();
      test_start_cal();
      test_show_next();
      test_timeout();
      test_reset_mid();
      test_random();
`ifdef SEQ_AUTO_ADV_EN
      test_auto_adv();
`else
      test_no_auto();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sensor_disp_seq.md
# sensor_disp_seq

Parametrised, clk-synchronous bring-up sequencer for the sensor interfaces. Drives a calibration request, waits for completion with a timeout, then steps through NUM_CH sensor channels on a debounced button pulse. Each step shows a configurable bit-slice of the selected channel on an LED bank. Sits between the push-button release detector and the inertial/sensor interface in board-level test tops.

## Interface
- NUM_CH, 3: number of sensor channels, ≥1.
- DATA_W, 16: width of each channel word.
- LED_W, 8: LED bank width, ≥2.
- SLICE_LSB, 1: LSB of the displayed slice; SLICE_LSB+LED_W ≤ DATA_W.
- CAL_TO, 1000000: calibration timeout in clk cycles, ≥2.
- AUTO_CYC, 50000000: auto-advance period in cycles (used only with SEQ_AUTO_ADV_EN).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- next  in  1  single-cycle step pulse, synchronous to clk (already debounced).
- cal_done  in  1  calibration complete; level or pulse.
- vld  in  1  new sample set on ch_data.
- ch_data  in  NUM_CH*DATA_W  packed channel words; channel k at [k*DATA_W +: DATA_W].
- strt_cal  out  1  one-cycle calibration request.
- cal_busy  out  1  high while in CAL.
- ch_sel  out  max(1,$clog2(NUM_CH))  displayed channel index.
- led  out  LED_W  display value.

## Operation
- States: IDLE, CAL, SHOW, ERR. All outputs registered.
- IDLE: led=0. A next pulse moves to CAL and asserts strt_cal for exactly one cycle.
- CAL: cal_busy=1, led={(LED_W-1)'0,1'b1}. next is ignored.
  - cal_done=1 → SHOW with ch_sel=0.
  - Timeout counter reaches CAL_TO-1 without cal_done → ERR.
  - cal_done on the timeout cycle: cal_done wins.
- ERR: led=all ones, cal_busy=0. next → CAL with a fresh one-cycle strt_cal; timeout counter restarts at 0.
- SHOW: hold register hreg (DATA_W) and led=hreg[SLICE_LSB +: LED_W].
  - vld=1 loads hreg from the word of channel ch_sel.
  - next=1 sets ch_sel to ch_sel+1, wrapping NUM_CH-1→0, and loads hreg from the new channel's word in the same edge.
  - next and vld together: next wins; the new channel is loaded.
  - NUM_CH=1: ch_sel stays 0 and next only reloads hreg.
- On SHOW entry, hreg loads channel 0 immediately.
- SHOW never returns to CAL. Only rst_n restarts the sequence.
- Reset, including mid-calibration: state=IDLE, strt_cal=0, cal_busy=0, ch_sel=0, led=0, hreg=0, all counters 0. A strt_cal already issued is not re-sent until the next pulse after reset.

## Timing
- next sampled at edge N → state/strt_cal/ch_sel update at N; led reflects the new state at N.
- strt_cal high for one cycle in the cycle after the next pulse edge.
- cal_done sampled at edge N → ch_sel=0 and led=channel 0 slice visible after edge N.
- vld at edge N → led updated after edge N. Latency is 1 cycle from input to led.
- Timeout: ERR entered CAL_TO cycles after CAL entry.

## Configuration
- SEQ_AUTO_ADV_EN defined:
  - In SHOW, a counter advances ch_sel (same rules as next) every AUTO_CYC cycles.
  - A next pulse advances and clears the counter.
  - The counter clears on SHOW entry.
- SEQ_AUTO_ADV_EN undefined: no counter is built, ch_sel changes only on next, and AUTO_CYC is unused.

## Test plan
- Reset then next: strt_cal=1 for exactly 1 cycle, cal_busy=1, led=8'h01; a second next during CAL produces no second strt_cal.
- cal_done 20 cycles into CAL with ch_data={16'h0300,16'h0200,16'h01FE}: ch_sel=0, led=8'hFF (16'h01FE[8:1]).
- Three next pulses: ch_sel 1,2,0 with led 8'h00, 8'h80, 8'hFF (slices [8:1] of 16'h0200, 16'h0300, 16'h01FE); next+vld in the same cycle loads the new channel.
- CAL_TO=100, no cal_done: ERR at cycle 100 with led=8'hFF; next gives a fresh strt_cal; cal_done on cycle 99 of the retry gives SHOW, not ERR.
- rst_n low mid-CAL and mid-SHOW: all outputs 0 asynchronously; IDLE on release.
- SEQ_AUTO_ADV_EN, AUTO_CYC=10: ch_sel increments every 10 cycles in SHOW; next at cycle 5 advances and restarts the 10-cycle count.
